// File: rtl/load_store_unit_pkg.sv
// Shared codes and helpers for the load/store unit: access size/sign codes,
// response error codes, FSM states, alignment and data shaping functions.
package load_store_unit_pkg;

  localparam logic [2:0] LOAD_BYTE   = 3'b000;
  localparam logic [2:0] LOAD_HALF   = 3'b001;
  localparam logic [2:0] LOAD_WORD   = 3'b010;
  localparam logic [2:0] LOAD_BYTE_U = 3'b100;
  localparam logic [2:0] LOAD_HALF_U = 3'b101;

  localparam logic [1:0] LSU_ERR_NONE          = 2'd0;
  localparam logic [1:0] LSU_ERR_MISALIGNED    = 2'd1;
  localparam logic [1:0] LSU_ERR_ILLEGAL_READ  = 2'd2;
  localparam logic [1:0] LSU_ERR_ILLEGAL_WRITE = 2'd3;

  typedef enum logic [1:0] {
    LSU_IDLE  = 2'd0,
    LSU_ISSUE = 2'd1,
    LSU_RESP  = 2'd2
  } lsu_state_t;

  // Access width comes from size[1:0]; bit 2 only selects unsigned extension.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [31:0] ea);
    logic r;
    case (size[1:0])
      2'b00:   r = 1'b0;
      2'b01:   r = ea[0];
      default: r = (ea[1:0] != 2'b00);
    endcase
    return r;
  endfunction

  function automatic logic [31:0] extend_load(input logic [2:0] size, input logic [31:0] d);
    logic [31:0] r;
    case (size)
      LOAD_BYTE:   r = {{24{d[7]}}, d[7:0]};
      LOAD_HALF:   r = {{16{d[15]}}, d[15:0]};
      LOAD_BYTE_U: r = {24'h0, d[7:0]};
      LOAD_HALF_U: r = {16'h0, d[15:0]};
      default:     r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] mask_store(input logic [2:0] size, input logic [31:0] d);
    logic [31:0] r;
    case (size[1:0])
      2'b00:   r = {24'h0, d[7:0]};
      2'b01:   r = {16'h0, d[15:0]};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_store_unit.sv
// Single-outstanding load/store sequencer between execute and memory.
// Optional LSU_PERF_COUNT_EN adds perf_loads/perf_stores/perf_errors counters.
//
// state     | meaning
// LSU_IDLE  | ready for a request; misaligned requests go straight to RESP
// LSU_ISSUE | one cycle driving memory; load data / fault captured at its end
// LSU_RESP  | response held until resp_ready
module load_store_unit
  import load_store_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_size_and_sign,
  input  logic [31:0] req_base,
  input  logic [31:0] req_offset,
  input  logic [31:0] req_store_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_load_data,
  output logic [1:0]  resp_error,
  output logic [31:0] resp_address,
  output logic [31:0] mem_read_address,
  output logic [31:0] mem_write_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write_enable,
  output logic [2:0]  mem_size_and_sign,
  input  logic [31:0] mem_read_data,
  input  logic        mem_illegal_read_address,
  input  logic        mem_illegal_write_address
`ifdef LSU_PERF_COUNT_EN
  ,
  output logic [31:0] perf_loads,
  output logic [31:0] perf_stores,
  output logic [31:0] perf_errors
`endif
);

  lsu_state_t  state, state_next;
  logic [31:0] ea;
  logic [31:0] ea_q;
  logic [31:0] store_data_q;
  logic [2:0]  size_q;
  logic        is_store_q;
  logic        accept;
  logic        misaligned;
  logic        resp_done;

  assign ea         = req_base + req_offset;
  assign misaligned = is_misaligned(req_size_and_sign, ea);
  assign accept     = req_valid && (state == LSU_IDLE);
  assign resp_done  = (state == LSU_RESP) && resp_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LSU_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next       = state;
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    mem_write_enable = 1'b0;
    case (state)
      LSU_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = misaligned ? LSU_RESP : LSU_ISSUE;
      end
      LSU_ISSUE: begin
        // Gated combinationally so an illegal store never pulses the write strobe.
        mem_write_enable = is_store_q && !mem_illegal_write_address;
        state_next       = LSU_RESP;
      end
      LSU_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = LSU_IDLE;
      end
      default: state_next = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ea_q           <= 32'h0;
      store_data_q   <= 32'h0;
      size_q         <= 3'h0;
      is_store_q     <= 1'b0;
      resp_load_data <= 32'h0;
      resp_error     <= LSU_ERR_NONE;
      resp_address   <= 32'h0;
    end else if (accept) begin
      ea_q           <= ea;
      store_data_q   <= mask_store(req_size_and_sign, req_store_data);
      size_q         <= req_size_and_sign;
      is_store_q     <= req_is_store;
      resp_load_data <= 32'h0;
      resp_error     <= misaligned ? LSU_ERR_MISALIGNED : LSU_ERR_NONE;
      resp_address   <= ea;
    end else if (state == LSU_ISSUE) begin
      if (is_store_q) begin
        resp_error <= mem_illegal_write_address ? LSU_ERR_ILLEGAL_WRITE : LSU_ERR_NONE;
      end else if (mem_illegal_read_address) begin
        resp_error     <= LSU_ERR_ILLEGAL_READ;
        resp_load_data <= 32'h0;
      end else begin
        resp_error     <= LSU_ERR_NONE;
        resp_load_data <= extend_load(size_q, mem_read_data);
      end
    end
  end

  assign mem_read_address  = ea_q;
  assign mem_write_address = ea_q;
  assign mem_write_data    = store_data_q;
  assign mem_size_and_sign = size_q;

`ifdef LSU_PERF_COUNT_EN
  // A faulting request is attributed only to perf_errors.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_loads  <= 32'h0;
      perf_stores <= 32'h0;
      perf_errors <= 32'h0;
    end else if (resp_done) begin
      if (resp_error != LSU_ERR_NONE) perf_errors <= perf_errors + 32'd1;
      else if (is_store_q)            perf_stores <= perf_stores + 32'd1;
      else                            perf_loads  <= perf_loads + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit with a behavioural memory peer (legal window 0x1000-0x1FFF)
// and an independent byte-array reference model.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_is_store;
  logic [2:0]  req_size_and_sign;
  logic [31:0] req_base, req_offset, req_store_data;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_load_data, resp_address;
  logic [1:0]  resp_error;
  logic [31:0] mem_read_address, mem_write_address, mem_write_data, mem_read_data;
  logic        mem_write_enable, mem_illegal_read_address, mem_illegal_write_address;
  logic [2:0]  mem_size_and_sign;
`ifdef LSU_PERF_COUNT_EN
  logic [31:0] perf_loads, perf_stores, perf_errors;
`endif

  int checks = 0;
  int errors = 0;
  int wr_pulses = 0;
  int we_rises = 0;
  int wdata_bad = 0;
  int exp_loads = 0, exp_stores = 0, exp_errors = 0;

  logic [7:0] mem_model [0:4095];
  logic [7:0] ref_mem   [0:4095];

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_size_and_sign(req_size_and_sign), .req_base(req_base), .req_offset(req_offset),
    .req_store_data(req_store_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_load_data(resp_load_data),
    .resp_error(resp_error), .resp_address(resp_address),
    .mem_read_address(mem_read_address), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_enable(mem_write_enable),
    .mem_size_and_sign(mem_size_and_sign), .mem_read_data(mem_read_data),
    .mem_illegal_read_address(mem_illegal_read_address),
    .mem_illegal_write_address(mem_illegal_write_address)
`ifdef LSU_PERF_COUNT_EN
    , .perf_loads(perf_loads), .perf_stores(perf_stores), .perf_errors(perf_errors)
`endif
  );

  function automatic logic in_region(input logic [31:0] a);
    return (a >= 32'h1000) && (a < 32'h2000);
  endfunction

  // Memory peer: returns the four bytes starting at the address, unshaped.
  always_comb begin
    logic [31:0] a;
    mem_read_data = 32'h0;
    for (int k = 0; k < 4; k++) begin
      a = mem_read_address + k;
      mem_read_data[k*8 +: 8] = in_region(a) ? mem_model[a[11:0]] : 8'h00;
    end
  end
  assign mem_illegal_read_address  = !in_region(mem_read_address);
  assign mem_illegal_write_address = !in_region(mem_write_address);

  always @(posedge clk) begin
    if (mem_write_enable) begin
      int w;
      logic [31:0] a;
      wr_pulses++;
      w = (mem_size_and_sign[1:0] == 2'b00) ? 1 : (mem_size_and_sign[1:0] == 2'b01) ? 2 : 4;
      if (w == 1 && mem_write_data[31:8] != 24'h0) wdata_bad++;
      if (w == 2 && mem_write_data[31:16] != 16'h0) wdata_bad++;
      for (int k = 0; k < w; k++) begin
        a = mem_write_address + k;
        if (in_region(a)) mem_model[a[11:0]] <= mem_write_data[k*8 +: 8];
      end
    end
  end

  always @(posedge mem_write_enable) we_rises++;

  // Reference: what a completed request must return, from plain address arithmetic.
  task automatic predict(input logic st, input logic [2:0] sz, input logic [31:0] base, off, data,
                         output logic [1:0] err, output logic [31:0] ld, addr,
                         output int lat, output int wr);
    logic [31:0] ea;
    longint v;
    int w;
    ea = base + off;
    w = (sz[1:0] == 2'b00) ? 1 : (sz[1:0] == 2'b01) ? 2 : 4;
    addr = ea; ld = 32'h0; wr = 0; lat = 2; err = LSU_ERR_NONE;
    if (ea % w != 0) begin
      err = LSU_ERR_MISALIGNED; lat = 1;
    end else if (st) begin
      if (in_region(ea)) begin
        for (int k = 0; k < w; k++) ref_mem[ea[11:0] + k] = data[k*8 +: 8];
        wr = 1;
      end else err = LSU_ERR_ILLEGAL_WRITE;
    end else if (in_region(ea)) begin
      v = 0;
      for (int k = 0; k < w; k++) v = v + (longint'(ref_mem[ea[11:0] + k]) << (8 * k));
      if (w < 4 && !sz[2] && v >= (64'd1 << (8 * w - 1))) v = v - (64'd1 << (8 * w));
      ld = v[31:0];
    end else err = LSU_ERR_ILLEGAL_READ;
    if (err != LSU_ERR_NONE) exp_errors++;
    else if (st) exp_stores++;
    else exp_loads++;
  endtask

  // Drives one request, holds resp_ready low for 'hold' cycles, returns what was observed.
  task automatic do_op(input logic st, input logic [2:0] sz, input logic [31:0] base, off, data,
                       input int hold, output logic [1:0] err, output logic [31:0] ld, addr,
                       output int lat, output int wr);
    int w0;
    w0 = wr_pulses;
    @(negedge clk);
    req_valid = 1'b1; req_is_store = st; req_size_and_sign = sz;
    req_base = base; req_offset = off; req_store_data = data;
    resp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!resp_valid && lat < 20);
    checks++;
    if (!resp_valid) begin
      errors++; $display("FAIL resp_timeout: resp_valid=%0b after %0d cycles, required 1", resp_valid, lat);
    end
    err = resp_error; ld = resp_load_data; addr = resp_address;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL ready_in_resp: req_ready=%0b, required 0", req_ready);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_error !== err ||
          resp_load_data !== ld || resp_address !== addr) begin
        errors++;
        $display("FAIL resp_hold: valid=%0b ready=%0b err=%0d data=%h addr=%h, required 1 0 %0d %h %h",
                 resp_valid, req_ready, resp_error, resp_load_data, resp_address, err, ld, addr);
      end
      if (i == hold - 1) resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL after_handshake: req_ready=%0b resp_valid=%0b, required 1 0", req_ready, resp_valid);
    end
    wr = wr_pulses - w0;
  endtask

  task automatic test_reset();
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_load_data !== 32'h0 ||
        resp_error !== 2'd0 || resp_address !== 32'h0 || mem_write_enable !== 1'b0 ||
        mem_read_address !== 32'h0 || mem_write_address !== 32'h0 || mem_write_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: ready=%0b valid=%0b data=%h err=%0d addr=%h we=%0b ra=%h wa=%h wd=%h, required 1 0 0 0 0 0 0 0 0",
               req_ready, resp_valid, resp_load_data, resp_error, resp_address, mem_write_enable,
               mem_read_address, mem_write_address, mem_write_data);
    end
  endtask

  task automatic test_store_load_word();
    logic [1:0] e, pe; logic [31:0] d, a, pd, pa; int l, w, pl, pw;
    predict(1'b1, LOAD_WORD, 32'h1000, 32'h0, 32'hDEADBEEF, pe, pd, pa, pl, pw);
    do_op(1'b1, LOAD_WORD, 32'h1000, 32'h0, 32'hDEADBEEF, 0, e, d, a, l, w);
    checks++;
    if (w != 1 || e !== LSU_ERR_NONE || l != 2) begin
      errors++; $display("FAIL store_word: writes=%0d err=%0d lat=%0d, required 1 0 2", w, e, l);
    end
    predict(1'b0, LOAD_WORD, 32'h1000, 32'h0, 32'h0, pe, pd, pa, pl, pw);
    do_op(1'b0, LOAD_WORD, 32'h1000, 32'h0, 32'h0, 0, e, d, a, l, w);
    checks++;
    if (d !== 32'hDEADBEEF || e !== LSU_ERR_NONE || l != 2 || w != 0) begin
      errors++; $display("FAIL load_word: data=%h err=%0d lat=%0d writes=%0d, required deadbeef 0 2 0", d, e, l, w);
    end
  endtask

  task automatic test_byte_sign();
    logic [1:0] e, pe; logic [31:0] d, a, pd, pa; int l, w, pl, pw;
    predict(1'b1, LOAD_BYTE, 32'h1004, 32'h0, 32'h12345680, pe, pd, pa, pl, pw);
    do_op(1'b1, LOAD_BYTE, 32'h1004, 32'h0, 32'h12345680, 0, e, d, a, l, w);
    predict(1'b0, LOAD_BYTE, 32'h1004, 32'h0, 32'h0, pe, pd, pa, pl, pw);
    do_op(1'b0, LOAD_BYTE, 32'h1004, 32'h0, 32'h0, 0, e, d, a, l, w);
    checks++;
    if (d !== 32'hFFFFFF80 || e !== LSU_ERR_NONE) begin
      errors++; $display("FAIL load_byte_signed: data=%h err=%0d, required ffffff80 0", d, e);
    end
    predict(1'b0, LOAD_BYTE_U, 32'h1004, 32'h0, 32'h0, pe, pd, pa, pl, pw);
    do_op(1'b0, LOAD_BYTE_U, 32'h1004, 32'h0, 32'h0, 0, e, d, a, l, w);
    checks++;
    if (d !== 32'h00000080 || e !== LSU_ERR_NONE) begin
      errors++; $display("FAIL load_byte_unsigned: data=%h err=%0d, required 00000080 0", d, e);
    end
  endtask

  task automatic test_misaligned();
    logic [1:0] e, pe; logic [31:0] d, a, pd, pa; int l, w, pl, pw, r0;
    r0 = we_rises;
    predict(1'b0, LOAD_HALF, 32'h1000, 32'h1, 32'h0, pe, pd, pa, pl, pw);
    do_op(1'b0, LOAD_HALF, 32'h1000, 32'h1, 32'h0, 0, e, d, a, l, w);
    checks++;
    if (e !== LSU_ERR_MISALIGNED || l != 1 || a !== 32'h1001 || w != 0 || d !== 32'h0 || we_rises != r0) begin
      errors++; $display("FAIL misaligned_half: err=%0d lat=%0d addr=%h writes=%0d data=%h, required 1 1 1001 0 0",
                         e, l, a, w, d);
    end
  endtask

  task automatic test_illegal();
    logic [1:0] e, pe; logic [31:0] d, a, pd, pa; int l, w, pl, pw, r0;
    r0 = we_rises;
    predict(1'b1, LOAD_WORD, 32'h3000, 32'h0, 32'hCAFEF00D, pe, pd, pa, pl, pw);
    do_op(1'b1, LOAD_WORD, 32'h3000, 32'h0, 32'hCAFEF00D, 0, e, d, a, l, w);
    checks++;
    if (e !== LSU_ERR_ILLEGAL_WRITE || we_rises != r0 || w != 0) begin
      errors++; $display("FAIL illegal_write: err=%0d we_rises=%0d, required 3 0", e, we_rises - r0);
    end
    predict(1'b0, LOAD_WORD, 32'h800, 32'h0, 32'h0, pe, pd, pa, pl, pw);
    do_op(1'b0, LOAD_WORD, 32'h800, 32'h0, 32'h0, 0, e, d, a, l, w);
    checks++;
    if (e !== LSU_ERR_ILLEGAL_READ || d !== 32'h0) begin
      errors++; $display("FAIL illegal_read: err=%0d data=%h, required 2 0", e, d);
    end
    predict(1'b0, LOAD_WORD, 32'hFFFFFFFC, 32'h8, 32'h0, pe, pd, pa, pl, pw);
    do_op(1'b0, LOAD_WORD, 32'hFFFFFFFC, 32'h8, 32'h0, 0, e, d, a, l, w);
    checks++;
    if (a !== 32'h4 || e !== LSU_ERR_ILLEGAL_READ || l != 2) begin
      errors++; $display("FAIL addr_wrap: addr=%h err=%0d lat=%0d, required 00000004 2 2", a, e, l);
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] e, pe; logic [31:0] d, a, pd, pa; int l, w, pl, pw;
    predict(1'b0, LOAD_HALF_U, 32'h1000, 32'h2, 32'h0, pe, pd, pa, pl, pw);
    do_op(1'b0, LOAD_HALF_U, 32'h1000, 32'h2, 32'h0, 5, e, d, a, l, w);
    checks++;
    if (e !== pe || d !== pd || a !== pa) begin
      errors++; $display("FAIL backpressure_resp: err=%0d data=%h addr=%h, required %0d %h %h", e, d, a, pe, pd, pa);
    end
  endtask

  task automatic test_random();
    logic [2:0] load_codes [5] = '{LOAD_BYTE, LOAD_HALF, LOAD_WORD, LOAD_BYTE_U, LOAD_HALF_U};
    logic [1:0] e, pe; logic [31:0] d, a, pd, pa, base, off, data; logic st; logic [2:0] sz;
    int l, w, pl, pw, hold;
    for (int n = 0; n < 80; n++) begin
      st = ($urandom_range(0, 1) == 1);
      sz = st ? load_codes[$urandom_range(0, 2)] : load_codes[$urandom_range(0, 4)];
      base = 32'h1000 + $urandom_range(0, 32'hF0) * 4;
      if ($urandom_range(0, 9) == 0) base = ($urandom_range(0, 1) == 1) ? 32'h3000 : 32'h0800;
      off = $urandom_range(0, 32) - 16;
      data = $urandom;
      hold = $urandom_range(0, 3);
      predict(st, sz, base, off, data, pe, pd, pa, pl, pw);
      do_op(st, sz, base, off, data, hold, e, d, a, l, w);
      checks++;
      if (e !== pe || d !== pd || a !== pa || l != pl || w != pw) begin
        errors++;
        $display("FAIL random_op%0d: st=%0b sz=%0d err=%0d data=%h addr=%h lat=%0d wr=%0d, required %0d %h %h %0d %0d",
                 n, st, sz, e, d, a, l, w, pe, pd, pa, pl, pw);
      end
    end
    checks++;
    if (wdata_bad != 0) begin
      errors++; $display("FAIL store_data_mask: unmasked writes=%0d, required 0", wdata_bad);
    end
  endtask

  task automatic test_reset_mid_issue();
    logic [1:0] e, pe; logic [31:0] d, a, pd, pa; int l, w, pl, pw;
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b1; req_size_and_sign = LOAD_WORD;
    req_base = 32'h1100; req_offset = 32'h0; req_store_data = 32'h55AA55AA; resp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (mem_write_enable !== 1'b1) begin
      errors++; $display("FAIL issue_we: mem_write_enable=%0b, required 1", mem_write_enable);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (mem_write_enable !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_mid_issue: we=%0b ready=%0b valid=%0b, required 0 1 0",
                         mem_write_enable, req_ready, resp_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    exp_loads = 0; exp_stores = 0; exp_errors = 0;
    predict(1'b0, LOAD_WORD, 32'h1100, 32'h0, 32'h0, pe, pd, pa, pl, pw);
    do_op(1'b0, LOAD_WORD, 32'h1100, 32'h0, 32'h0, 0, e, d, a, l, w);
    checks++;
    if (d !== pd || e !== pe) begin
      errors++; $display("FAIL discarded_store: data=%h err=%0d, required %h %0d", d, e, pd, pe);
    end
  endtask

  task automatic test_perf();
`ifdef LSU_PERF_COUNT_EN
    checks++;
    if (perf_loads !== exp_loads || perf_stores !== exp_stores || perf_errors !== exp_errors) begin
      errors++; $display("FAIL perf_counters: loads=%0d stores=%0d errors=%0d, required %0d %0d %0d",
                         perf_loads, perf_stores, perf_errors, exp_loads, exp_stores, exp_errors);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem_model[i] = 8'($urandom);
      ref_mem[i] = mem_model[i];
    end
    reset = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_size_and_sign = 3'h0;
    req_base = 32'h0; req_offset = 32'h0; req_store_data = 32'h0; resp_ready = 1'b1;
    #12;
    test_reset();
    @(negedge clk);
    reset = 1'b0;
    test_store_load_word();
    test_byte_sign();
    test_misaligned();
    test_illegal();
    test_backpressure();
    test_random();
    test_perf();
    test_reset_mid_issue();
    test_perf();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
